// File: rtl/program_loader_if.sv
// Byte-stream input and RAM port-A / status bundle of the program loader.
// The loader side uses the slave modport; the stream source/system side uses master.
interface program_loader_if;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        ena;
   logic        wea;
   logic [9:0]  addra;
   logic [15:0] dia;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_rst;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, ena, wea, addra, dia, busy, done, error, cpu_rst
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, ena, wea, addra, dia, busy, done, error, cpu_rst
   );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream as 16-bit words into RAM port A, holding the CPU in reset until done.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEN_HI  | expecting word-count high byte
// LEN_LO  | expecting word-count low byte, range checked on acceptance
// DATA_HI | expecting opcode (high) byte of next word
// DATA_LO | expecting operand (low) byte, word latched onto dia
// WRITE   | one-cycle RAM write of dia at addra
// CHECK   | expecting checksum byte (LOADER_CHECKSUM_EN only)
// DONE    | image loaded, CPU released
// ERR     | bad length or checksum, CPU held in reset
module program_loader #(
   parameter logic [9:0] BASE_ADDR = 10'd0,
   parameter int         MAX_WORDS = 1024
) (
   input  logic            clka,
   input  logic            rst,
   program_loader_if.slave bus
);

   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] LEN_HI  = 4'd1;
   localparam logic [3:0] LEN_LO  = 4'd2;
   localparam logic [3:0] DATA_HI = 4'd3;
   localparam logic [3:0] DATA_LO = 4'd4;
   localparam logic [3:0] WRITE   = 4'd5;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [3:0] CHECK   = 4'd6;
   localparam logic [3:0] AFTER_DATA = CHECK;
`else
   localparam logic [3:0] AFTER_DATA = 4'd7;
`endif
   localparam logic [3:0] DONE    = 4'd7;
   localparam logic [3:0] ERR     = 4'd8;

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   logic [3:0]  state;
   logic [3:0]  state_nxt;
   logic [15:0] len;
   logic [15:0] cnt;
   logic [15:0] cnt_inc;
   logic [15:0] len_new;
   logic [7:0]  hi_byte;
   logic [15:0] dia_q;
   logic [9:0]  addra_q;
   logic        rdy;
   logic        take;
   logic        idle_like;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
   assign cnt_inc   = cnt + 16'd1;
   assign len_new   = {len[15:8], bus.in_data};

   always_comb begin
      rdy = 1'b0;
      case (state)
         LEN_HI, LEN_LO, DATA_HI, DATA_LO: rdy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         CHECK:                            rdy = 1'b1;
`endif
         default:                          rdy = 1'b0;
      endcase
   end

   assign take = rdy & bus.in_valid;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (bus.start) state_nxt = LEN_HI;
         LEN_HI:          if (take) state_nxt = LEN_LO;
         LEN_LO: begin
            if (take) begin
               if ({1'b0, len_new} > MAX_LEN)  state_nxt = ERR;
               else if (len_new == 16'd0)      state_nxt = AFTER_DATA;
               else                            state_nxt = DATA_HI;
            end
         end
         DATA_HI:         if (take) state_nxt = DATA_LO;
         DATA_LO:         if (take) state_nxt = WRITE;
         WRITE:           state_nxt = (cnt_inc < len) ? DATA_HI : AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
         CHECK:           if (take) state_nxt = (bus.in_data == csum) ? DONE : ERR;
`endif
         default:         state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         len     <= 16'd0;
         cnt     <= 16'd0;
         hi_byte <= 8'd0;
         dia_q   <= 16'd0;
         addra_q <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
         csum    <= 8'd0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE, DONE, ERR: begin
               if (bus.start) begin
                  cnt     <= 16'd0;
                  addra_q <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                  csum    <= 8'd0;
`endif
               end
            end
            LEN_HI: if (take) len[15:8] <= bus.in_data;
            LEN_LO: if (take) len[7:0]  <= bus.in_data;
            DATA_HI: begin
               if (take) begin
                  hi_byte <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                  csum    <= csum ^ bus.in_data;
`endif
               end
            end
            DATA_LO: begin
               if (take) begin
                  dia_q <= {hi_byte, bus.in_data};
`ifdef LOADER_CHECKSUM_EN
                  csum  <= csum ^ bus.in_data;
`endif
               end
            end
            WRITE: begin
               addra_q <= addra_q + 10'd1;
               cnt     <= cnt_inc;
            end
            default: ;
         endcase
      end
   end

   // All handshake/status outputs are pure state decodes so reset clears them asynchronously.
   assign bus.in_ready = rdy;
   assign bus.ena      = (state == WRITE);
   assign bus.wea      = (state == WRITE);
   assign bus.addra    = addra_q;
   assign bus.dia      = dia_q;
   assign bus.busy     = ~idle_like;
   assign bus.done     = (state == DONE);
   assign bus.error    = (state == ERR);
   assign bus.cpu_rst  = (state != DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (BASE_ADDR=1023 so every multi-word load exercises address wrap).
// Expectations follow whether LOADER_CHECKSUM_EN is defined for the build.
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
   localparam logic CSUM = 1'b1;
`else
   localparam logic CSUM = 1'b0;
`endif

   logic clka = 1'b0;
   logic rst  = 1'b1;
   always #5 clka = ~clka;

   program_loader_if bus ();

   program_loader #(.BASE_ADDR(10'd1023), .MAX_WORDS(1024)) u_dut (
      .clka (clka),
      .rst  (rst),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [9:0]  wr_addr[$];
   logic [15:0] wr_data[$];
   int          wea_run     = 0;
   int          wea_run_max = 0;
   int          ena_bad     = 0;

   always @(negedge clka) begin
      if (bus.wea === 1'b1) begin
         wr_addr.push_back(bus.addra);
         wr_data.push_back(bus.dia);
         wea_run++;
         if (wea_run > wea_run_max) wea_run_max = wea_run;
      end else begin
         wea_run = 0;
      end
      if (bus.ena !== bus.wea) ena_bad++;
   end

   logic [7:0] tx_q[$];
   logic [7:0] tb_xor;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic timeout(input string tag);
      checks++;
      failures++;
      $display("FAIL %s: observed=timeout expected=event within bound", tag);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      repeat (gap) step();
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) timeout("in_ready");
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic send_all(input int gap);
      logic [7:0] b;
      while (tx_q.size() > 0) begin
         b = tx_q.pop_front();
         send_byte(b, gap);
      end
   endtask

   task automatic wait_not_busy();
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) timeout("busy_release");
   endtask

   task automatic push_len(input logic [15:0] n);
      tx_q.push_back(n[15:8]);
      tx_q.push_back(n[7:0]);
   endtask

   task automatic push_word(input logic [15:0] w);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
      tb_xor = tb_xor ^ w[15:8] ^ w[7:0];
   endtask

   task automatic begin_load();
      wr_addr.delete();
      wr_data.delete();
      tx_q.delete();
      wea_run_max = 0;
      ena_bad     = 0;
      tb_xor      = 8'h00;
      bus.start   = 1'b1;
      step();
      bus.start   = 1'b0;
   endtask

   task automatic chk_write(input string tag, input int idx, input logic [9:0] a, input logic [15:0] d);
      chk({tag, "_addr"}, 32'(wr_addr[idx]), 32'(a));
      chk({tag, "_data"}, 32'(wr_data[idx]), 32'(d));
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      tb_xor       = 8'h00;
      repeat (3) step();

      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_ena",      32'(bus.ena),      32'd0);
      chk("rst_wea",      32'(bus.wea),      32'd0);
      chk("rst_addra",    32'(bus.addra),    32'd1023);
      chk("rst_dia",      32'(bus.dia),      32'd0);
      chk("rst_busy",     32'(bus.busy),     32'd0);
      chk("rst_done",     32'(bus.done),     32'd0);
      chk("rst_error",    32'(bus.error),    32'd0);
      chk("rst_cpu_rst",  32'(bus.cpu_rst),  32'd1);

      // Load A: start on the very first edge after reset release, two words wrapping 1023 -> 0
      rst = 1'b0;
      begin_load();
      chk("A_busy",     32'(bus.busy),     32'd1);
      chk("A_in_ready", 32'(bus.in_ready), 32'd1);
      chk("A_cpu_rst",  32'(bus.cpu_rst),  32'd1);
      push_len(16'd2);
      push_word(16'h1111);
      push_word(16'h2222);
      if (CSUM) tx_q.push_back(tb_xor);
      send_all(0);
      wait_not_busy();
      chk("A_done",    32'(bus.done),    32'd1);
      chk("A_error",   32'(bus.error),   32'd0);
      chk("A_cpu_rst_rel", 32'(bus.cpu_rst), 32'd0);
      chk("A_nwr",     32'(wr_addr.size()), 32'd2);
      chk_write("A_w0", 0, 10'd1023, 16'h1111);
      chk_write("A_w1", 1, 10'd0,    16'h2222);
      chk("A_wea_pulse", 32'(wea_run_max), 32'd1);
      chk("A_ena_eq_wea", 32'(ena_bad), 32'd0);
      chk("A_addra_end", 32'(bus.addra), 32'd1);

      // Stream activity in DONE is ignored
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
      repeat (4) step();
      bus.in_valid = 1'b0;
      chk("Q_done",     32'(bus.done),     32'd1);
      chk("Q_busy",     32'(bus.busy),     32'd0);
      chk("Q_in_ready", 32'(bus.in_ready), 32'd0);
      chk("Q_nwr",      32'(wr_addr.size()), 32'd2);

      // Load B: length 0x0401 exceeds MAX_WORDS
      begin_load();
      chk("B_done_clr", 32'(bus.done), 32'd0);
      push_len(16'h0401);
      send_all(0);
      chk("B_error",   32'(bus.error),   32'd1);
      chk("B_busy",    32'(bus.busy),    32'd0);
      chk("B_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      step();
      chk("B_nwr",     32'(wr_addr.size()), 32'd0);

      // Load C: data XOR is 0x11, checksum slot carries 0x04
      begin_load();
      chk("C_error_clr", 32'(bus.error), 32'd0);
      push_len(16'd2);
      push_word(16'h0100);
      push_word(16'h0010);
      if (CSUM) tx_q.push_back(8'h04);
      send_all(0);
      wait_not_busy();
      chk("C_error",   32'(bus.error),   32'(CSUM));
      chk("C_done",    32'(bus.done),    32'(!CSUM));
      chk("C_cpu_rst", 32'(bus.cpu_rst), 32'(CSUM));
      chk("C_nwr",     32'(wr_addr.size()), 32'd2);
      chk_write("C_w0", 0, 10'd1023, 16'h0100);
      chk_write("C_w1", 1, 10'd0,    16'h0010);

      // Load D: empty image
      begin_load();
      push_len(16'd0);
      if (CSUM) tx_q.push_back(8'h00);
      send_all(0);
      wait_not_busy();
      chk("D_done",  32'(bus.done),  32'd1);
      chk("D_error", 32'(bus.error), 32'd0);
      step();
      chk("D_nwr",   32'(wr_addr.size()), 32'd0);
      chk("D_addra", 32'(bus.addra), 32'd1023);

      // Load E: in_valid toggling, start pulses while busy
      begin_load();
      push_len(16'd3);
      push_word(16'hA55A);
      push_word(16'h0F0F);
      push_word(16'h1234);
      if (CSUM) tx_q.push_back(tb_xor);
      for (int i = 0; tx_q.size() > 0; i++) begin
         if (i == 3 || i == 6) begin
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
         end
         send_byte(tx_q.pop_front(), 1);
      end
      wait_not_busy();
      chk("E_done",  32'(bus.done),  32'd1);
      chk("E_error", 32'(bus.error), 32'd0);
      chk("E_nwr",   32'(wr_addr.size()), 32'd3);
      chk_write("E_w0", 0, 10'd1023, 16'hA55A);
      chk_write("E_w1", 1, 10'd0,    16'h0F0F);
      chk_write("E_w2", 2, 10'd1,    16'h1234);
      chk("E_wea_pulse", 32'(wea_run_max), 32'd1);

      // Load F: reset lands in the WRITE cycle of word 5
      begin_load();
      push_len(16'd6);
      for (int k = 1; k <= 6; k++) push_word(16'(k) * 16'h0101);
      for (int i = 0; i < 12; i++) send_byte(tx_q.pop_front(), 0);
      chk("F_wea_w5",   32'(bus.wea),   32'd1);
      chk("F_addra_w5", 32'(bus.addra), 32'd3);
      chk("F_dia_w5",   32'(bus.dia),   32'h0505);
      rst = 1'b1;
      #1;
      chk("F_rst_wea",      32'(bus.wea),      32'd0);
      chk("F_rst_ena",      32'(bus.ena),      32'd0);
      chk("F_rst_busy",     32'(bus.busy),     32'd0);
      chk("F_rst_addra",    32'(bus.addra),    32'd1023);
      chk("F_rst_dia",      32'(bus.dia),      32'd0);
      chk("F_rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("F_rst_cpu_rst",  32'(bus.cpu_rst),  32'd1);
      step();
      chk("F_nwr", 32'(wr_addr.size()), 32'd4);
      step();
      rst = 1'b0;

      // Reload after the interrupted image
      begin_load();
      push_len(16'd1);
      push_word(16'h0403);
      if (CSUM) tx_q.push_back(tb_xor);
      send_all(0);
      wait_not_busy();
      chk("G_done",    32'(bus.done),    32'd1);
      chk("G_cpu_rst", 32'(bus.cpu_rst), 32'd0);
      chk("G_nwr",     32'(wr_addr.size()), 32'd1);
      chk_write("G_w0", 0, 10'd1023, 16'h0403);
      chk("G_wea_pulse", 32'(wea_run_max), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
